// File: rtl/movavg_pkg.sv
// movavg_pkg: shared constants and types for the movavg sequencer.
//   MOVAVG_TAPS  window length of the downstream datapath
//   MOVAVG_W     default sample/sum width
//   sample_t     default-width sample
//   pair_state_t pairing FSM states
//   obuf_state_t output buffer phases
package movavg_pkg;

    localparam int unsigned MOVAVG_TAPS = 4;
    localparam int unsigned MOVAVG_W    = 64;

    typedef logic [MOVAVG_W-1:0] sample_t;

    typedef enum logic [1:0] {
        Idle,
        Half,
        Flush0,
        Flush1
    } pair_state_t;

    typedef enum logic [1:0] {
        Empty,
        BPend,
        APend
    } obuf_state_t;

endpackage

// File: rtl/movavg_obuf.sv
// movavg_obuf: two-entry buffer that captures a (sumB, sumA) pair in one cycle and
// presents it as two beats (sumB first) on a valid/ready stream.
// Optional build macro MOVAVG_CTRL_DIV_EN: present sum >> log2(MOVAVG_TAPS) instead of
// the raw wrapped sum. Timing is the same in both builds.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   load_i            capture sum_a_i/sum_b_i (only when empty or A is draining)
//   sum_a_i, sum_b_i  window sums from the datapath
//   out_ready_i       downstream ready
//   out_data_o        current beat (0 while empty)
//   out_valid_o       a beat is pending
//   empty_o, a_pend_o phase flags used by the issuer
module movavg_obuf
    import movavg_pkg::*;
#(
    parameter int unsigned W = MOVAVG_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] sum_a_i,
    input  logic [W-1:0] sum_b_i,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    output logic         empty_o,
    output logic         a_pend_o
);

    obuf_state_t  state_q, state_d;
    logic [W-1:0] sum_a_q, sum_a_d;
    logic [W-1:0] sum_b_q, sum_b_d;
    logic [W-1:0] raw;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Empty;
            sum_a_q <= '0;
            sum_b_q <= '0;
        end else begin
            state_q <= state_d;
            sum_a_q <= sum_a_d;
            sum_b_q <= sum_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sum_a_d = sum_a_q;
        sum_b_d = sum_b_q;
        unique case (state_q)
            Empty: if (load_i) state_d = BPend;
            BPend: if (out_ready_i) state_d = APend;
            // A new pair may land on the same edge the A beat leaves.
            APend: if (out_ready_i) state_d = load_i ? BPend : Empty;
            default: state_d = Empty;
        endcase
        if (load_i) begin
            sum_a_d = sum_a_i;
            sum_b_d = sum_b_i;
        end
    end

    always_comb begin
        raw = '0;
        if (state_q == BPend) raw = sum_b_q;
        if (state_q == APend) raw = sum_a_q;
    end

`ifdef MOVAVG_CTRL_DIV_EN
    assign out_data_o = raw >> $clog2(MOVAVG_TAPS);
`else
    assign out_data_o = raw;
`endif

    assign out_valid_o = (state_q != Empty);
    assign empty_o     = (state_q == Empty);
    assign a_pend_o    = (state_q == APend);

endmodule

// File: rtl/movavg_ctrl.sv
// movavg_ctrl: sequencer in front of a 2-lane, 4-tap moving-sum datapath.
// Pairs a serial sample stream into lanes (dinB = older, dinA = newer), enables the
// datapath one pair at a time, drops warm-up results, re-serialises the two sums and
// implements flush by injecting two zero pairs.
// Optional build macro MOVAVG_CTRL_DIV_EN (handled in movavg_obuf): output the
// 4-sample average instead of the raw sum.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   in_data/in_valid/in_ready      input sample stream
//   flush, flush_busy              restart request, zero-pair injection in progress
//   out_data/out_valid/out_ready   output sum stream (sumB then sumA per pair)
//   dp_en, dp_dinA, dp_dinB        datapath advance strobe and lanes
//   dp_doutA, dp_doutB             combinational datapath sums
module movavg_ctrl
    import movavg_pkg::*;
#(
    parameter int unsigned W            = MOVAVG_W,
    parameter int unsigned WARMUP_PAIRS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic         flush_busy,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         dp_en,
    output logic [W-1:0] dp_dinA,
    output logic [W-1:0] dp_dinB,
    input  logic [W-1:0] dp_doutA,
    input  logic [W-1:0] dp_doutB
);

    // Wide enough to hold WARMUP_PAIRS, and at least one bit when it is 0.
    localparam int unsigned     CntW    = $clog2(WARMUP_PAIRS + 2);
    localparam logic [CntW-1:0] WarmMax = CntW'(WARMUP_PAIRS);

    pair_state_t     state_q, state_d;
    logic [W-1:0]    hold_q, hold_d;
    logic [CntW-1:0] warm_q, warm_d;

    logic warm_done;
    logic can_issue;
    logic obuf_load;
    logic obuf_empty;
    logic obuf_a_pend;

    assign warm_done = (warm_q >= WarmMax);
    // Warm-up results are discarded, so they never need buffer space.
    assign can_issue = ~warm_done | obuf_empty | (obuf_a_pend & out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= Idle;
            hold_q  <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            warm_q  <= warm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        warm_d     = warm_q;
        in_ready   = 1'b0;
        flush_busy = 1'b0;
        dp_en      = 1'b0;
        dp_dinA    = '0;
        dp_dinB    = '0;
        obuf_load  = 1'b0;
        unique case (state_q)
            Idle: begin
                if (flush) begin
                    state_d = Flush0;
                    warm_d  = '0;
                end else begin
                    // Keep in_ready low while reset is held.
                    in_ready = ~reset;
                    if (in_valid) begin
                        hold_d  = in_data;
                        state_d = Half;
                    end
                end
            end
            Half: begin
                if (flush) begin
                    // Held half-pair is discarded.
                    state_d = Flush0;
                    warm_d  = '0;
                    hold_d  = '0;
                end else begin
                    in_ready = can_issue;
                    if (in_valid && can_issue) begin
                        dp_en   = 1'b1;
                        dp_dinB = hold_q;
                        dp_dinA = in_data;
                        state_d = Idle;
                        if (warm_done) begin
                            obuf_load = 1'b1;
                        end else begin
                            warm_d = warm_q + 1'b1;
                        end
                    end
                end
            end
            Flush0: begin
                dp_en      = 1'b1;
                flush_busy = 1'b1;
                state_d    = Flush1;
            end
            Flush1: begin
                dp_en      = 1'b1;
                flush_busy = 1'b1;
                state_d    = Idle;
            end
            default: state_d = Idle;
        endcase
    end

    movavg_obuf #(
        .W(W)
    ) u_obuf (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (obuf_load),
        .sum_a_i    (dp_doutA),
        .sum_b_i    (dp_doutB),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_valid_o(out_valid),
        .empty_o    (obuf_empty),
        .a_pend_o   (obuf_a_pend)
    );

endmodule

// File: tb/tb_movavg_ctrl.sv
// tb_movavg_ctrl: self-checking bench for movavg_ctrl with a behavioural 4-tap datapath
// and a scoreboard of expected output beats built from a sample-history model.
module tb_movavg_ctrl;
    import movavg_pkg::*;

    localparam int unsigned W  = 64;
    localparam int unsigned WP = 2;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    sample_t in_data = '0;
    logic    in_valid = 1'b0;
    logic    in_ready;
    logic    flush = 1'b0;
    logic    flush_busy;
    sample_t out_data;
    logic    out_valid;
    logic    out_ready = 1'b1;
    logic    dp_en;
    sample_t dp_dinA, dp_dinB, dp_doutA, dp_doutB;
    sample_t tap1, tap2, tap3;

    always #5 clk = ~clk;

    movavg_ctrl #(
        .W           (W),
        .WARMUP_PAIRS(WP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .flush_busy(flush_busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dp_en     (dp_en),
        .dp_dinA   (dp_dinA),
        .dp_dinB   (dp_dinB),
        .dp_doutA  (dp_doutA),
        .dp_doutB  (dp_doutB)
    );

    // Datapath: tap1 = previous dinA, tap2 = previous dinB, tap3 = dinA two pairs back.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tap1 <= '0;
            tap2 <= '0;
            tap3 <= '0;
        end else if (dp_en) begin
            tap3 <= tap1;
            tap1 <= dp_dinA;
            tap2 <= dp_dinB;
        end
    end
    assign dp_doutA = dp_dinA + dp_dinB + tap1 + tap2;
    assign dp_doutB = dp_dinB + tap1 + tap2 + tap3;

    int checks = 0;
    int errors = 0;

    // Monitor
    int      cyc = 0;
    sample_t obs_q[$];
    sample_t exp_q[$];
    int      en_cyc_q[$];
    int      rise_cyc_q[$];
    int      dp_en_cnt = 0;
    int      zero_en_cnt = 0;
    int      fb_cnt = 0;
    int      ov_cnt = 0;
    logic    ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) obs_q.push_back(out_data);
            if (dp_en) begin
                dp_en_cnt <= dp_en_cnt + 1;
                en_cyc_q.push_back(cyc);
                if (dp_dinA == '0 && dp_dinB == '0) zero_en_cnt <= zero_en_cnt + 1;
            end
            if (flush_busy) fb_cnt <= fb_cnt + 1;
            if (out_valid) ov_cnt <= ov_cnt + 1;
            if (out_valid && !ov_prev) rise_cyc_q.push_back(cyc);
        end
        ov_prev <= out_valid;
    end

    // Reference model: sample history since reset/flush (flush zeroes the window).
    sample_t m_hold, m_h0, m_h1, m_h2;
    bit      m_half;
    int      m_pairs;

    function automatic sample_t fmt(input sample_t s);
`ifdef MOVAVG_CTRL_DIV_EN
        return s >> 2;
`else
        return s;
`endif
    endfunction

    task automatic model_clear();
        m_hold = '0; m_h0 = '0; m_h1 = '0; m_h2 = '0;
        m_half = 1'b0;
        m_pairs = 0;
    endtask

    task automatic model_accept(input sample_t x);
        sample_t sb, sa;
        if (!m_half) begin
            m_hold = x;
            m_half = 1'b1;
        end else begin
            sb = m_hold + m_h0 + m_h1 + m_h2;
            sa = x + m_hold + m_h0 + m_h1;
            if (m_pairs >= int'(WP)) begin
                exp_q.push_back(fmt(sb));
                exp_q.push_back(fmt(sa));
            end else begin
                m_pairs++;
            end
            m_h2 = m_h0;
            m_h1 = m_hold;
            m_h0 = x;
            m_half = 1'b0;
        end
    endtask

    // Offer one sample; returns at posedge+1 after it is accepted.
    task automatic send(input sample_t x);
        bit ok = 1'b0;
        in_data = x;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (ok) model_accept(x);
        else begin
            errors++;
            $display("FAIL send_timeout sample %0h not accepted within 100 cycles", x);
        end
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        model_clear();
        obs_q.delete();
        exp_q.delete();
        en_cyc_q.delete();
        rise_cyc_q.delete();
        #1 reset = 1'b0;
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 200 && obs_q.size() < n; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks += 7;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL rst_out_data got %0h want 0", out_data); end
        if (dp_en !== 1'b0) begin errors++; $display("FAIL rst_dp_en got %b want 0", dp_en); end
        if (dp_dinA !== '0) begin errors++; $display("FAIL rst_dinA got %0h want 0", dp_dinA); end
        if (dp_dinB !== '0) begin errors++; $display("FAIL rst_dinB got %0h want 0", dp_dinB); end
        if (flush_busy !== 1'b0) begin errors++; $display("FAIL rst_flush_busy got %b want 0", flush_busy); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic(input string tag);
        int ov0;
        sample_t got, want;
        apply_reset();
        ov0 = ov_cnt;
        for (int i = 1; i <= 8; i++) send(sample_t'(i));
        wait_out(4);
        checks++;
        if (ov_cnt - ov0 != 4) begin
            errors++; $display("FAIL %s_valid_cycles got %0d want 4", tag, ov_cnt - ov0);
        end
        checks++;
        if (rise_cyc_q.size() != 1 || en_cyc_q.size() < 3) begin
            errors++;
            $display("FAIL %s_valid_rises got %0d rises/%0d enables want 1/4", tag,
                     rise_cyc_q.size(), en_cyc_q.size());
        end else if (rise_cyc_q[0] != en_cyc_q[2] + 1) begin
            errors++;
            $display("FAIL %s_latency got cycle %0d want %0d", tag, rise_cyc_q[0], en_cyc_q[2] + 1);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_count got %0d want %0d", tag, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL %s_data got %0d want %0d", tag, got, want); end
        end
    endtask

    task automatic test_backpressure();
        sample_t got, want;
        apply_reset();
        fork
            begin
                for (int i = 1; i <= 8; i++) send(sample_t'(i));
            end
            begin
                bit seen = 1'b0;
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) seen = 1'b1;
                end
                checks++;
                if (!seen) begin
                    errors++; $display("FAIL bp_no_valid got 0 want out_valid within 200 cycles");
                end else begin
                    out_ready = 1'b0;
                    for (int j = 0; j < 5; j++) begin
                        @(negedge clk);
                        checks += 2;
                        if (out_data !== fmt(64'd14)) begin
                            errors++; $display("FAIL bp_hold got %0d want %0d", out_data, fmt(64'd14));
                        end
                        if (dp_en !== 1'b0) begin errors++; $display("FAIL bp_dp_en got %b want 0", dp_en); end
                        if (j >= 1) begin
                            checks++;
                            if (in_ready !== 1'b0) begin
                                errors++; $display("FAIL bp_in_ready got %b want 0", in_ready);
                            end
                        end
                    end
                    @(posedge clk);
                    #1 out_ready = 1'b1;
                end
            end
        join
        wait_out(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL bp_data got %0d want %0d", got, want); end
        end
    endtask

    task automatic test_flush();
        int en0, fb0, z0;
        sample_t got, want;
        apply_reset();
        for (int i = 1; i <= 5; i++) send(sample_t'(i));
        en0 = dp_en_cnt;
        fb0 = fb_cnt;
        z0 = zero_en_cnt;
        flush = 1'b1;
        model_clear();
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks += 3;
        if (fb_cnt - fb0 != 2) begin errors++; $display("FAIL fl_busy_cycles got %0d want 2", fb_cnt - fb0); end
        if (dp_en_cnt - en0 != 2) begin errors++; $display("FAIL fl_dp_en got %0d want 2", dp_en_cnt - en0); end
        if (zero_en_cnt - z0 != 2) begin
            errors++; $display("FAIL fl_zero_lanes got %0d want 2", zero_en_cnt - z0);
        end
        for (int i = 10; i <= 17; i++) send(sample_t'(i));
        wait_out(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL fl_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL fl_data got %0d want %0d", got, want); end
        end
    endtask

    task automatic test_all_ones();
        sample_t got, want, first_want;
`ifdef MOVAVG_CTRL_DIV_EN
        first_want = 64'h3FFF_FFFF_FFFF_FFFF;
`else
        first_want = 64'hFFFF_FFFF_FFFF_FFFC;
`endif
        apply_reset();
        for (int i = 0; i < 8; i++) send('1);
        wait_out(4);
        checks++;
        if (obs_q.size() == 0) begin
            errors++; $display("FAIL ones_first got none want %0h", first_want);
        end else if (obs_q[0] !== first_want) begin
            errors++; $display("FAIL ones_first got %0h want %0h", obs_q[0], first_want);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL ones_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL ones_data got %0h want %0h", got, want); end
        end
    endtask

    task automatic test_flush_collision();
        sample_t got, want;
        apply_reset();
        in_data = 64'd99;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL col_in_ready got %b want 0", in_ready); end
        if (flush_busy !== 1'b0) begin errors++; $display("FAIL col_busy0 got %b want 0", flush_busy); end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        checks += 2;
        if (flush_busy !== 1'b1) begin errors++; $display("FAIL col_busy1 got %b want 1", flush_busy); end
        if (dp_en !== 1'b1) begin errors++; $display("FAIL col_dp_en got %b want 1", dp_en); end
        @(negedge clk);
        checks++;
        if (flush_busy !== 1'b1) begin errors++; $display("FAIL col_busy2 got %b want 1", flush_busy); end
        @(negedge clk);
        checks += 2;
        if (flush_busy !== 1'b0) begin errors++; $display("FAIL col_busy3 got %b want 0", flush_busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL col_idle got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++) send(sample_t'(i));
        wait_out(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++; $display("FAIL col_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin errors++; $display("FAIL col_data got %0d want %0d", got, want); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 1; i <= 6; i++) send(sample_t'(i));
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL ar_data got %0h want 0", out_data); end
        test_basic("ar_replay");
    endtask

    initial begin
        test_reset();
        test_basic("basic");
        test_backpressure();
        test_flush();
        test_all_ones();
        test_flush_collision();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
